multi_driver_resolver: RTL and testbench
========================================

Name: multi_driver_resolver

Overview:
- Registered, parametrised N-driver four-state net resolver for W-bit nets.
- Each transaction resolves NDRV driver codes per bit under a selectable net kind: wire, wand, wor, tri1, tri0 or trireg.
- Produces the resolved four-state word and per-bit contention flags, and keeps a saturating contention counter.
- Sits between the stimulus generator and checker in the multi-driven-net test harness, and replaces ad hoc wand/wor/tri1 net resolution with one valid/ready pipelined unit.

Parameters:
- NDRV, 3, number of drivers per net (>=2).
- W, 4, net width in bits.
- DECAY, 3, trireg charge lifetime in accepted transactions (>=1).
- CW, 8, width of the contention counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  transaction offered.
- in_ready  out  1  transaction can be accepted.
- mode  in  3  net kind: 0 wire, 1 wand, 2 wor, 3 tri1, 4 tri0, 5 trireg, 6/7 reserved.
- drv_code  in  NDRV*W*2  driver d, bit b is at [(d*W+b)*2 +: 2]; encoding 00=0, 01=1, 10=z, 11=x.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- res_code  out  W*2  resolved code per bit, same encoding as drv_code.
- out_conflict  out  W  per-bit contention mask for the held result.
- out_mode_err  out  1  held result was produced under a reserved mode.
- conflict_cnt  out  CW  count of transactions with any contention.
- clr_cnt  in  1  synchronous clear of conflict_cnt.

Behaviour:
- Reset (rst_n=0 at an edge) sets:
  - out_valid=0;
  - res_code all 10 (z);
  - out_conflict=0, out_mode_err=0, conflict_cnt=0;
  - trireg hold register all 11 (x);
  - per-bit decay counters 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transaction is accepted when in_valid && in_ready.
  - Latency is 1: the result is registered and out_valid=1 on the next cycle.
  - While out_valid && !out_ready, res_code, out_conflict and out_mode_err hold stable.
  - Accept and output in the same cycle gives full throughput.
  - If there is no accept and out_ready=1, out_valid drops to 0.
- mode and drv_code are sampled only at acceptance.
- Per-bit base resolution:
  - Let S be the set of non-z driver codes.
  - wire: S empty -> z; any x in S -> x; S has both 0 and 1 -> x; otherwise the common value.
  - wand: any 0 -> 0; else any x -> x; else any 1 -> 1; else z.
  - wor: any 1 -> 1; else any x -> x; else any 0 -> 0; else z.
  - tri1 / tri0: wire rule, with a z result replaced by 1 / 0.
  - trireg: wire rule.
    - On a z result the output is hold[b].
    - Increment dec[b], saturating at DECAY. When dec[b] reaches DECAY, hold[b] becomes x and the output is x.
    - On a non-z result, hold[b] takes that result and dec[b]=0.
  - Reserved modes resolve as wire and set out_mode_err=1.
- hold/dec update only on accepted trireg transactions. Other modes leave them untouched.
- Contention:
  - out_conflict[b]=1 when S for bit b contains both 0 and 1, in any mode except wand and wor (there it is always 0).
  - x drivers alone never flag contention.
- conflict_cnt increments by 1 per accepted transaction whose contention mask is nonzero, saturating at 2^CW-1.
  - clr_cnt has priority: if clear and increment happen in the same cycle, the result is 0.
- Reset asserted mid-transaction discards the held result; no partial output appears.
- Combinational resolution is NDRV-generic (loop over drivers); no fixed-width special cases.

Test Plan:
- Reset, then wire mode with drv_code (bit0) d0=0, d1=1, d2=z -> next cycle res bit0=x, out_conflict[0]=1, conflict_cnt=1.
- wand mode with bit0 d0=1, d1=0, d2=x -> res bit0=0, out_conflict=0, conflict_cnt unchanged; wor mode with the same drivers -> res bit0=1.
- tri1 and tri0 with all drivers z on all bits -> res_code all 01 and all 00 respectively, out_conflict=0.
- trireg, DECAY=3:
  - bit0 driven 1 once, then 4 all-z transactions -> results 1,1,1,x,x;
  - then a mode-0 transaction and a return to trireg with all z -> still x, and hold is not reloaded.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, res_code stable; out_ready=1 -> one transfer per cycle with no loss or duplication.
- Saturation and clear, CW=2:
  - 5 contended transactions -> conflict_cnt=3;
  - clr_cnt asserted together with a contended accept -> 0;
  - mode=6 -> out_mode_err=1 with wire result.

Source files
------------

// File: rtl/multi_driver_resolver_if.sv
// Valid/ready bundle for the multi-driver net resolver.
// master = stimulus/checker side, slave = resolver.
interface multi_driver_resolver_if #(
   parameter int NDRV = 3,
   parameter int W    = 4,
   parameter int CW   = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [2:0]          mode;
   logic [NDRV*W*2-1:0] drv_code;
   logic                clr_cnt;
   logic                out_valid;
   logic                out_ready;
   logic [W*2-1:0]      res_code;
   logic [W-1:0]        out_conflict;
   logic                out_mode_err;
   logic [CW-1:0]       conflict_cnt;

   modport master (
      output in_valid, mode, drv_code, clr_cnt, out_ready,
      input  in_ready, out_valid, res_code, out_conflict,
      input  out_mode_err, conflict_cnt
   );

   modport slave (
      input  in_valid, mode, drv_code, clr_cnt, out_ready,
      output in_ready, out_valid, res_code, out_conflict,
      output out_mode_err, conflict_cnt
   );
endinterface

// File: rtl/multi_driver_resolver.sv
// Registered N-driver four-state net resolver (wire/wand/wor/tri1/tri0/trireg).
// Codes: 00=0 01=1 10=z 11=x; one-cycle latency valid/ready output stage.
module multi_driver_resolver #(
   parameter int NDRV  = 3,
   parameter int W     = 4,
   parameter int DECAY = 3,
   parameter int CW    = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   multi_driver_resolver_if.slave bus
);
   localparam int DW = $clog2(DECAY + 1);

   localparam logic [1:0] C0 = 2'b00;
   localparam logic [1:0] C1 = 2'b01;
   localparam logic [1:0] CZ = 2'b10;
   localparam logic [1:0] CX = 2'b11;

   localparam logic [2:0] M_WAND   = 3'd1;
   localparam logic [2:0] M_WOR    = 3'd2;
   localparam logic [2:0] M_TRI1   = 3'd3;
   localparam logic [2:0] M_TRI0   = 3'd4;
   localparam logic [2:0] M_TRIREG = 3'd5;

   localparam logic [CW-1:0] CMAX = '1;

   logic                    r_out_valid;
   logic [W-1:0][1:0]       r_res;
   logic [W-1:0]            r_conf;
   logic                    r_merr;
   logic [CW-1:0]           r_cnt;
   logic [W-1:0][1:0]       r_hold;
   logic [W-1:0][DW-1:0]    r_dec;

   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_mode_err;
   logic [W-1:0][1:0]       w_res;
   logic [W-1:0]            w_conf;
   logic [W-1:0][1:0]       w_hold_n;
   logic [W-1:0][DW-1:0]    w_dec_n;
   logic                    w_h0;
   logic                    w_h1;
   logic                    w_hx;
   logic [1:0]              w_c;
   logic [1:0]              w_wr;
   logic [DW-1:0]           w_inc;

   always_comb begin
      w_in_ready = !r_out_valid || bus.out_ready;
      w_accept   = bus.in_valid && w_in_ready;
      w_mode_err = (bus.mode > M_TRIREG);
      w_res      = '0;
      w_conf     = '0;
      w_hold_n   = r_hold;
      w_dec_n    = r_dec;
      w_h0       = 1'b0;
      w_h1       = 1'b0;
      w_hx       = 1'b0;
      w_c        = CZ;
      w_wr       = CZ;
      w_inc      = '0;
      for (int b = 0; b < W; b++) begin
         w_h0 = 1'b0;
         w_h1 = 1'b0;
         w_hx = 1'b0;
         for (int d = 0; d < NDRV; d++) begin
            w_c  = bus.drv_code[(d*W+b)*2 +: 2];
            w_h0 = w_h0 | (w_c == C0);
            w_h1 = w_h1 | (w_c == C1);
            w_hx = w_hx | (w_c == CX);
         end
         if (w_hx || (w_h0 && w_h1))
            w_wr = CX;
         else if (w_h1)
            w_wr = C1;
         else if (w_h0)
            w_wr = C0;
         else
            w_wr = CZ;
         w_inc = (r_dec[b] == DW'(DECAY)) ? r_dec[b]
                                           : r_dec[b] + 1'b1;
         w_conf[b] = w_h0 && w_h1;
         unique case (bus.mode)
            M_WAND: begin
               w_conf[b] = 1'b0;
               w_res[b]  = w_h0 ? C0 : w_hx ? CX : w_h1 ? C1 : CZ;
            end
            M_WOR: begin
               w_conf[b] = 1'b0;
               w_res[b]  = w_h1 ? C1 : w_hx ? CX : w_h0 ? C0 : CZ;
            end
            M_TRI1: w_res[b] = (w_wr == CZ) ? C1 : w_wr;
            M_TRI0: w_res[b] = (w_wr == CZ) ? C0 : w_wr;
            M_TRIREG: begin
               // undriven: stored charge survives until DECAY idle accepts
               if (w_wr == CZ) begin
                  w_dec_n[b] = w_inc;
                  if (w_inc == DW'(DECAY)) begin
                     w_hold_n[b] = CX;
                     w_res[b]    = CX;
                  end else begin
                     w_res[b] = r_hold[b];
                  end
               end else begin
                  w_hold_n[b] = w_wr;
                  w_dec_n[b]  = '0;
                  w_res[b]    = w_wr;
               end
            end
            default: w_res[b] = w_wr;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_res       <= {W{CZ}};
         r_conf      <= '0;
         r_merr      <= 1'b0;
         r_cnt       <= '0;
         r_hold      <= {W{CX}};
         r_dec       <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res;
            r_conf      <= w_conf;
            r_merr      <= w_mode_err;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept && bus.mode == M_TRIREG) begin
            r_hold <= w_hold_n;
            r_dec  <= w_dec_n;
         end
         if (bus.clr_cnt)
            r_cnt <= '0;
         else if (w_accept && |w_conf && r_cnt != CMAX)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.res_code     = r_res;
   assign bus.out_conflict = r_conf;
   assign bus.out_mode_err = r_merr;
   assign bus.conflict_cnt = r_cnt;
endmodule

// File: tb/tb_multi_driver_resolver.sv
// Scoreboard bench for multi_driver_resolver.
// Expected words are queued at accept and compared at transfer.
module tb_multi_driver_resolver;
   localparam int NDRV  = 3;
   localparam int W     = 4;
   localparam int DECAY = 3;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   localparam logic [1:0] L0 = 2'b00;
   localparam logic [1:0] L1 = 2'b01;
   localparam logic [1:0] LZ = 2'b10;
   localparam logic [1:0] LX = 2'b11;

   typedef logic [NDRV*W*2-1:0] drv_t;

   typedef struct packed {
      logic [2*W-1:0] res;
      logic [W-1:0]   conf;
      logic           merr;
      logic [CW-1:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_driver_resolver_if #(.NDRV(NDRV), .W(W), .CW(CW)) bus ();

   multi_driver_resolver #(
      .NDRV(NDRV), .W(W), .DECAY(DECAY), .CW(CW)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   exp_t       q[$];
   exp_t       mon_e;
   int         n_chk  = 0;
   int         n_pass = 0;
   int         n_push = 0;
   int         n_pop  = 0;
   logic [1:0] m_hold[W];
   int         m_dec[W];
   int         m_cnt;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic drv_t allz();
      return {NDRV*W{LZ}};
   endfunction

   function automatic drv_t put(input drv_t c, input int d, input int b,
                                input logic [1:0] v);
      drv_t r;
      r = c;
      r[(d*W+b)*2 +: 2] = v;
      return r;
   endfunction

   task automatic model(input logic [2:0] m, input drv_t c, input logic clr);
      exp_t       e;
      logic [1:0] wr;
      logic [1:0] r;
      int         n0, n1, nx;
      e = '0;
      for (int b = 0; b < W; b++) begin
         n0 = 0; n1 = 0; nx = 0;
         for (int d = 0; d < NDRV; d++) begin
            case (c[(d*W+b)*2 +: 2])
               L0: n0++;
               L1: n1++;
               LX: nx++;
               default: ;
            endcase
         end
         if (nx > 0 || (n0 > 0 && n1 > 0)) wr = LX;
         else if (n1 > 0) wr = L1;
         else if (n0 > 0) wr = L0;
         else wr = LZ;
         r = wr;
         case (m)
            3'd1: r = (n0 > 0) ? L0 : (nx > 0) ? LX : (n1 > 0) ? L1 : LZ;
            3'd2: r = (n1 > 0) ? L1 : (nx > 0) ? LX : (n0 > 0) ? L0 : LZ;
            3'd3: if (wr == LZ) r = L1;
            3'd4: if (wr == LZ) r = L0;
            3'd5: begin
               if (wr == LZ) begin
                  if (m_dec[b] < DECAY) m_dec[b]++;
                  if (m_dec[b] == DECAY) m_hold[b] = LX;
                  r = m_hold[b];
               end else begin
                  m_hold[b] = wr;
                  m_dec[b]  = 0;
               end
            end
            default: ;
         endcase
         e.res[2*b +: 2] = r;
         e.conf[b] = (m != 3'd1 && m != 3'd2 && n0 > 0 && n1 > 0);
      end
      e.merr = (m > 3'd5);
      if (clr) m_cnt = 0;
      else if (e.conf != '0 && m_cnt < CMAX) m_cnt++;
      e.cnt = m_cnt[CW-1:0];
      q.push_back(e);
      n_push++;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", q.size(), 1);
            end else begin
               mon_e = q.pop_front();
               n_pop++;
               chk("res_code", bus.res_code, mon_e.res);
               chk("out_conflict", bus.out_conflict, mon_e.conf);
               chk("out_mode_err", bus.out_mode_err, mon_e.merr);
               chk("conflict_cnt", bus.conflict_cnt, mon_e.cnt);
            end
         end
         if (bus.in_valid && bus.in_ready)
            model(bus.mode, bus.drv_code, bus.clr_cnt);
      end
   end

   task automatic send(input logic [2:0] m, input drv_t c, input logic clr);
      bit ok;
      ok = 1'b0;
      bus.mode     = m;
      bus.drv_code = c;
      bus.clr_cnt  = clr;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.clr_cnt  = 1'b0;
      if (!ok) chk("send_timeout", ok, 1);
   endtask

   task automatic drain();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      drv_t       c;
      logic [1:0] tr_exp[5];
      tr_exp = '{L1, L1, L1, LX, LX};
      bus.in_valid  = 1'b0;
      bus.mode      = 3'd0;
      bus.drv_code  = allz();
      bus.clr_cnt   = 1'b0;
      bus.out_ready = 1'b1;
      for (int b = 0; b < W; b++) begin
         m_hold[b] = LX;
         m_dec[b]  = 0;
      end
      m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_res_code", bus.res_code, 8'hAA);
      chk("rst_conflict", bus.out_conflict, 0);
      chk("rst_mode_err", bus.out_mode_err, 0);
      chk("rst_cnt", bus.conflict_cnt, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst_n = 1'b1;

      c = put(put(allz(), 0, 0, L0), 1, 0, L1);
      send(3'd0, c, 1'b0);
      chk("wire_bit0", bus.res_code[1:0], LX);
      chk("wire_conf", bus.out_conflict, 4'b0001);
      chk("wire_cnt", bus.conflict_cnt, 1);

      c = put(put(put(allz(), 0, 0, L1), 1, 0, L0), 2, 0, LX);
      send(3'd1, c, 1'b0);
      chk("wand_bit0", bus.res_code[1:0], L0);
      chk("wand_conf", bus.out_conflict, 0);
      chk("wand_cnt", bus.conflict_cnt, 1);
      send(3'd2, c, 1'b0);
      chk("wor_bit0", bus.res_code[1:0], L1);

      send(3'd3, allz(), 1'b0);
      chk("tri1_res", bus.res_code, 8'h55);
      send(3'd4, allz(), 1'b0);
      chk("tri0_res", bus.res_code, 8'h00);
      chk("tri0_conf", bus.out_conflict, 0);

      send(3'd5, put(allz(), 0, 0, L1), 1'b0);
      chk("trireg_load", bus.res_code[1:0], L1);
      for (int i = 0; i < 4; i++) begin
         send(3'd5, allz(), 1'b0);
         chk("trireg_decay", bus.res_code[1:0], tr_exp[i+1]);
      end
      send(3'd0, allz(), 1'b0);
      chk("wire_allz", bus.res_code[1:0], LZ);
      send(3'd5, allz(), 1'b0);
      chk("trireg_stays_x", bus.res_code[1:0], LX);

      drain();
      bus.out_ready = 1'b0;
      send(3'd0, {NDRV*W{L1}}, 1'b0);
      bus.mode     = 3'd0;
      bus.drv_code = put(allz(), 0, 1, L1);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_hold", bus.res_code, 8'h55);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(3'd0, put(allz(), 0, 1, L1), 1'b0);
      send(3'd4, put(allz(), 2, 3, L1), 1'b0);
      send(3'd2, put(allz(), 1, 2, L0), 1'b0);
      drain();
      chk("bp_sb_empty", q.size(), 0);
      chk("bp_push_pop", n_pop, n_push);

      c = put(put(allz(), 0, 0, L0), 1, 0, L1);
      repeat (5) send(3'd0, c, 1'b0);
      chk("cnt_sat", bus.conflict_cnt, CMAX);
      send(3'd0, c, 1'b1);
      chk("cnt_clr", bus.conflict_cnt, 0);

      c = put(put(allz(), 0, 0, L1), 1, 0, L1);
      c = put(put(c, 0, 1, L0), 1, 1, L1);
      send(3'd6, c, 1'b0);
      chk("rsv_mode_err", bus.out_mode_err, 1);
      chk("rsv_res", bus.res_code, 8'hAD);
      chk("rsv_conf", bus.out_conflict, 4'b0010);
      chk("rsv_cnt", bus.conflict_cnt, 1);

      drain();
      chk("end_sb_empty", q.size(), 0);
      chk("end_push_pop", n_pop, n_push);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
